// File: rtl/text_console.sv
// text_console: teletype-style writer into 80x25 text-mode video RAM.
// Accepts bytes over valid/ready, writes char/attr cell pairs, tracks the
// cursor, and scrolls by copying video RAM one byte per read/write pair.
module text_console #(
  parameter logic [15:0] BASE     = 16'h8000,
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 25,
  parameter logic [7:0]  DEF_ATTR = 8'h07
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  din,
  input  logic [7:0]  attr,
  input  logic        valid,
  output logic        ready,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d,
  output logic        mem_we,
  input  logic [7:0]  mem_q,
  output logic [11:0] cursor
);

  localparam logic [11:0] COLS_W        = 12'(COLS);
  localparam logic [11:0] CELLS         = 12'(COLS * ROWS);
  localparam logic [11:0] CLR_BYTES     = 12'(2 * COLS * ROWS);
  localparam logic [11:0] FILL_BYTES    = 12'(2 * COLS);
  localparam logic [11:0] SCR_LAST      = 12'(2 * COLS * (ROWS - 1) - 1);
  localparam logic [15:0] ROW1_ADDR     = BASE + 16'(2 * COLS);
  localparam logic [15:0] LAST_ROW_ADDR = BASE + 16'(2 * COLS * (ROWS - 1));

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WR_CH,
    WR_AT,
    SCROLL_RD,
    SCROLL_WR,
    FILL
  } state_t;

  state_t      state, state_n;
  logic [11:0] cnt, cnt_n;        // byte index within CLEAR / scroll / FILL
  logic [11:0] cur_q, cur_n;
  logic [11:0] col_q, col_n;      // cursor mod COLS, kept alongside cursor
  logic [11:0] pend_q, pend_n;    // cursor value to publish once a scroll ends
  logic [7:0]  attr_q, attr_n;
  logic [15:0] a_q, a_n;
  logic [7:0]  d_q, d_n;
  logic        we_q, we_n;
  logic        rdy_q, rdy_n;

  logic        adv;
  logic [11:0] adv_cur;
  logic [11:0] adv_col;
  logic [11:0] tab_stop;

  assign ready  = rdy_q;
  assign mem_a  = a_q;
  assign mem_we = we_q;
  assign cursor = cur_q;
  // Copy data arrives the cycle after the read address, so it bypasses the
  // data register during the write half of each scroll pair.
  assign mem_d  = (state == SCROLL_WR) ? mem_q : d_q;

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= CLEAR;
      cnt    <= '0;
      cur_q  <= '0;
      col_q  <= '0;
      pend_q <= '0;
      attr_q <= DEF_ATTR;
      a_q    <= BASE;
      d_q    <= '0;
      we_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cur_q  <= cur_n;
      col_q  <= col_n;
      pend_q <= pend_n;
      attr_q <= attr_n;
      a_q    <= a_n;
      d_q    <= d_n;
      we_q   <= we_n;
      rdy_q  <= rdy_n;
    end
  end

  // Next-state, next-output and cursor movement logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cur_n    = cur_q;
    col_n    = col_q;
    pend_n   = pend_q;
    attr_n   = attr_q;
    a_n      = a_q;
    d_n      = d_q;
    we_n     = 1'b0;
    rdy_n    = 1'b0;
    adv      = 1'b0;
    adv_cur  = cur_q;
    adv_col  = col_q;
    tab_stop = {col_q[11:3] + 9'd1, 3'b000};
    if (tab_stop > COLS_W) begin
      tab_stop = COLS_W;
    end

    case (state)
      CLEAR: begin
        if (cnt == CLR_BYTES) begin
          state_n = IDLE;
          rdy_n   = 1'b1;
          cur_n   = '0;
          col_n   = '0;
          cnt_n   = '0;
        end else begin
          a_n   = BASE + 16'(cnt);
          d_n   = cnt[0] ? attr_q : 8'h20;
          we_n  = 1'b1;
          cnt_n = cnt + 12'd1;
        end
      end

      IDLE: begin
        // ready is held low for one settling cycle after a scroll
        rdy_n = 1'b1;
        if (rdy_q && valid) begin
          attr_n = attr;
          if (din >= 8'h20) begin
            state_n = WR_CH;
            a_n     = BASE + {3'b000, cur_q, 1'b0};
            d_n     = din;
            we_n    = 1'b1;
            rdy_n   = 1'b0;
          end else begin
            case (din)
              8'h0D: begin
                adv     = 1'b1;
                adv_cur = cur_q - col_q;
                adv_col = '0;
              end
              8'h0A: begin
                adv     = 1'b1;
                adv_cur = cur_q + COLS_W;
              end
              8'h08: begin
                if (col_q != '0) begin
                  adv     = 1'b1;
                  adv_cur = cur_q - 12'd1;
                  adv_col = col_q - 12'd1;
                end
              end
              8'h09: begin
                adv     = 1'b1;
                adv_cur = cur_q - col_q + tab_stop;
                adv_col = (tab_stop == COLS_W) ? '0 : tab_stop;
              end
              8'h0C: begin
                state_n = CLEAR;
                a_n     = BASE;
                d_n     = 8'h20;
                we_n    = 1'b1;
                cnt_n   = 12'd1;
                rdy_n   = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end

      WR_CH: begin
        state_n = WR_AT;
        a_n     = a_q + 16'd1;
        d_n     = attr_q;
        we_n    = 1'b1;
      end

      WR_AT: begin
        adv     = 1'b1;
        adv_cur = cur_q + 12'd1;
        adv_col = (col_q + 12'd1 == COLS_W) ? '0 : col_q + 12'd1;
      end

      SCROLL_RD: begin
        state_n = SCROLL_WR;
        a_n     = BASE + 16'(cnt);
        we_n    = 1'b1;
      end

      SCROLL_WR: begin
        if (cnt == SCR_LAST) begin
          state_n = FILL;
          a_n     = LAST_ROW_ADDR;
          d_n     = 8'h20;
          we_n    = 1'b1;
          cnt_n   = 12'd1;
        end else begin
          state_n = SCROLL_RD;
          cnt_n   = cnt + 12'd1;
          a_n     = ROW1_ADDR + 16'(cnt) + 16'd1;
        end
      end

      FILL: begin
        if (cnt == FILL_BYTES) begin
          state_n = IDLE;
          cur_n   = pend_q;
          cnt_n   = '0;
        end else begin
          a_n   = LAST_ROW_ADDR + 16'(cnt);
          d_n   = cnt[0] ? attr_q : 8'h20;
          we_n  = 1'b1;
          cnt_n = cnt + 12'd1;
        end
      end

      default: begin
        state_n = CLEAR;
        cnt_n   = '0;
      end
    endcase

    // A cursor move either lands directly or, past the last cell, defers the
    // cursor update until the scroll and fill have finished.
    if (adv) begin
      col_n = adv_col;
      if (adv_cur >= CELLS) begin
        state_n = SCROLL_RD;
        cnt_n   = '0;
        a_n     = ROW1_ADDR;
        pend_n  = adv_cur - COLS_W;
        rdy_n   = 1'b0;
      end else begin
        state_n = IDLE;
        cur_n   = adv_cur;
        rdy_n   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Testbench for text_console: video RAM model plus a write scoreboard.
module tb_text_console;

  localparam logic [15:0] BASE = 16'h8000;

  logic        clock;
  logic        reset_n;
  logic [7:0]  din;
  logic [7:0]  attr;
  logic        valid;
  logic        ready;
  logic [15:0] mem_a;
  logic [7:0]  mem_d;
  logic        mem_we;
  logic [7:0]  mem_q;
  logic [11:0] cursor;

  text_console #(
    .BASE(16'h8000),
    .COLS(80),
    .ROWS(25),
    .DEF_ATTR(8'h07)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .din(din),
    .attr(attr),
    .valid(valid),
    .ready(ready),
    .mem_a(mem_a),
    .mem_d(mem_d),
    .mem_we(mem_we),
    .mem_q(mem_q),
    .cursor(cursor)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Video RAM: synchronous write, read data registered one cycle after address.
  logic [7:0]  ram [0:4095];
  logic [11:0] ram_idx;
  assign ram_idx = 12'(mem_a - BASE);
  always @(posedge clock) begin
    if (mem_we) ram[ram_idx] <= mem_d;
    mem_q <= ram[ram_idx];
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] model [0:3999];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         mcur     = 0;

  function automatic void push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
    model[int'(a - BASE)] = d;
  endfunction

  function automatic void push_clear(input logic [7:0] a);
    for (int i = 0; i < 4000; i++) push_wr(BASE + 16'(i), i[0] ? a : 8'h20);
  endfunction

  function automatic void push_scroll(input logic [7:0] a);
    for (int i = 0; i < 3840; i++) push_wr(BASE + 16'(i), model[160 + i]);
    for (int i = 0; i < 160; i++) push_wr(BASE + 16'(3840 + i), i[0] ? a : 8'h20);
  endfunction

  // Advance one cycle, sample after the edge, and retire any write seen.
  task automatic tick();
    wr_t e;
    @(posedge clock);
    #1;
    if (mem_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got %h=%h, required no write", mem_a, mem_d);
      end else begin
        e = exp_q.pop_front();
        if (mem_a !== e.a || mem_d !== e.d) begin
          n_fail++;
          $display("FAIL wr_seq: got %h=%h, required %h=%h", mem_a, mem_d, e.a, e.d);
        end
      end
    end
  endtask

  task automatic wait_ready(input int limit, output int off);
    off = 1;
    while (ready !== 1'b1 && off < limit) begin
      tick();
      off++;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a, output int off);
    din   = d;
    attr  = a;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_ready(9000, off);
  endtask

  task automatic put_char(input logic [7:0] d, input logic [7:0] a);
    int off;
    push_wr(BASE + 16'(2 * mcur), d);
    push_wr(BASE + 16'(2 * mcur + 1), a);
    send(d, a, off);
    mcur++;
  endtask

  task automatic test_reset();
    int off;
    reset_n = 1'b0;
    valid   = 1'b0;
    din     = '0;
    attr    = '0;
    repeat (3) tick();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", ready); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b, required 0", mem_we); end
    n_checks++; if (mem_a !== BASE) begin n_fail++; $display("FAIL rst_addr: got %h, required %h", mem_a, BASE); end
    n_checks++; if (mem_d !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h, required 00", mem_d); end
    n_checks++; if (cursor !== 12'd0) begin n_fail++; $display("FAIL rst_cursor: got %0d, required 0", cursor); end
    push_clear(8'h07);
    reset_n = 1'b1;
    tick();
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL clear_start: we got %b, required 1", mem_we); end
    wait_ready(5000, off);
    n_checks++; if (off !== 4001) begin n_fail++; $display("FAIL clear_ready: rose at cycle %0d, required 4001", off); end
    n_checks++; if (cursor !== 12'd0) begin n_fail++; $display("FAIL clear_cursor: got %0d, required 0", cursor); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clear_count: %0d writes missing, required 0", exp_q.size()); end
    mcur = 0;
  endtask

  task automatic test_printable();
    int off;
    push_wr(16'h8000, 8'h41);
    push_wr(16'h8001, 8'h1E);
    din   = 8'h41;
    attr  = 8'h1E;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_a !== 16'h8000) begin n_fail++; $display("FAIL pr_n1: we=%b addr=%h, required 1 8000", mem_we, mem_a); end
    n_checks++; if (cursor !== 12'd0 || ready !== 1'b0) begin n_fail++; $display("FAIL pr_n1_state: cursor=%0d ready=%b, required 0 0", cursor, ready); end
    wait_ready(10, off);
    n_checks++; if (off !== 3) begin n_fail++; $display("FAIL pr_latency: ready at N+%0d, required N+3", off); end
    n_checks++; if (cursor !== 12'd1) begin n_fail++; $display("FAIL pr_cursor: got %0d, required 1", cursor); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pr_count: %0d writes missing, required 0", exp_q.size()); end
    mcur = 1;
  endtask

  task automatic test_back_to_back();
    int off;
    push_wr(BASE + 16'(2 * mcur), 8'h50);
    push_wr(BASE + 16'(2 * mcur + 1), 8'h11);
    push_wr(BASE + 16'(2 * mcur + 2), 8'h51);
    push_wr(BASE + 16'(2 * mcur + 3), 8'h12);
    din   = 8'h50;
    attr  = 8'h11;
    valid = 1'b1;
    tick();
    din  = 8'h51;
    attr = 8'h12;
    wait_ready(10, off);
    n_checks++; if (off !== 3) begin n_fail++; $display("FAIL b2b_first: ready at N+%0d, required N+3", off); end
    tick();
    valid = 1'b0;
    wait_ready(10, off);
    n_checks++; if (off !== 3) begin n_fail++; $display("FAIL b2b_second: ready at N+%0d, required N+3", off); end
    mcur = mcur + 2;
    n_checks++; if (cursor !== 12'(mcur)) begin n_fail++; $display("FAIL b2b_cursor: got %0d, required %0d", cursor, mcur); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_count: %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_control();
    int off;
    repeat (9) send(8'h09, 8'h07, off);
    n_checks++; if (cursor !== 12'd72) begin n_fail++; $display("FAIL tab_run: got %0d, required 72", cursor); end
    mcur = 72;
    repeat (7) put_char(8'h61, 8'h07);
    send(8'h09, 8'h07, off);
    n_checks++; if (off !== 1 || cursor !== 12'd80) begin n_fail++; $display("FAIL tab_wrap: N+%0d cursor=%0d, required N+1 80", off, cursor); end
    mcur = 80;
    repeat (5) put_char(8'h62, 8'h07);
    n_checks++; if (cursor !== 12'd85) begin n_fail++; $display("FAIL ctl_pos: got %0d, required 85", cursor); end
    send(8'h0D, 8'h07, off);
    n_checks++; if (off !== 1 || cursor !== 12'd80) begin n_fail++; $display("FAIL cr: N+%0d cursor=%0d, required N+1 80", off, cursor); end
    send(8'h0A, 8'h07, off);
    n_checks++; if (off !== 1 || cursor !== 12'd160) begin n_fail++; $display("FAIL lf: N+%0d cursor=%0d, required N+1 160", off, cursor); end
    send(8'h08, 8'h07, off);
    n_checks++; if (off !== 1 || cursor !== 12'd160) begin n_fail++; $display("FAIL bs_col0: N+%0d cursor=%0d, required N+1 160", off, cursor); end
    mcur = 160;
    repeat (3) put_char(8'h63, 8'h07);
    send(8'h09, 8'h07, off);
    n_checks++; if (cursor !== 12'd168) begin n_fail++; $display("FAIL tab_mid: got %0d, required 168", cursor); end
    send(8'h08, 8'h07, off);
    n_checks++; if (cursor !== 12'd167) begin n_fail++; $display("FAIL bs: got %0d, required 167", cursor); end
    send(8'h01, 8'h07, off);
    n_checks++; if (off !== 1 || cursor !== 12'd167) begin n_fail++; $display("FAIL ignored: N+%0d cursor=%0d, required N+1 167", off, cursor); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ctl_count: %0d writes missing, required 0", exp_q.size()); end
    mcur = 167;
  endtask

  task automatic test_form_feed();
    int off;
    send(8'h0D, 8'h07, off);
    repeat (4) send(8'h0A, 8'h07, off);
    repeat (2) send(8'h09, 8'h07, off);
    mcur = 496;
    repeat (4) put_char(8'h64, 8'h07);
    n_checks++; if (cursor !== 12'd500) begin n_fail++; $display("FAIL ff_pos: got %0d, required 500", cursor); end
    push_clear(8'h70);
    send(8'h0C, 8'h70, off);
    n_checks++; if (off !== 4001) begin n_fail++; $display("FAIL ff_ready: ready at N+%0d, required N+4001", off); end
    n_checks++; if (cursor !== 12'd0) begin n_fail++; $display("FAIL ff_cursor: got %0d, required 0", cursor); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ff_count: %0d writes missing, required 0", exp_q.size()); end
    n_checks++; if (ram[1001] !== 8'h70 || ram[1000] !== 8'h20) begin n_fail++; $display("FAIL ff_ram: got %h %h, required 20 70", ram[1000], ram[1001]); end
    mcur = 0;
  endtask

  task automatic test_scroll();
    int off;
    send(8'h0A, 8'h07, off);
    mcur = 80;
    repeat (80) put_char(8'h42, 8'h2F);
    repeat (22) send(8'h0A, 8'h07, off);
    repeat (9) send(8'h09, 8'h07, off);
    mcur = 1992;
    repeat (7) put_char(8'h45, 8'h07);
    n_checks++; if (cursor !== 12'd1999) begin n_fail++; $display("FAIL scr_pos: got %0d, required 1999", cursor); end
    push_wr(16'h8F9E, 8'h43);
    push_wr(16'h8F9F, 8'h07);
    push_scroll(8'h07);
    send(8'h43, 8'h07, off);
    n_checks++; if (off !== 7844) begin n_fail++; $display("FAIL scr_ready: ready at N+%0d, required N+7844", off); end
    n_checks++; if (cursor !== 12'd1920) begin n_fail++; $display("FAIL scr_cursor: got %0d, required 1920", cursor); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scr_count: %0d writes missing, required 0", exp_q.size()); end
    n_checks++; if (ram[0] !== 8'h42 || ram[1] !== 8'h2F) begin n_fail++; $display("FAIL scr_row0: got %h %h, required 42 2F", ram[0], ram[1]); end
    n_checks++; if (ram[3838] !== 8'h43 || ram[3839] !== 8'h07) begin n_fail++; $display("FAIL scr_row23: got %h %h, required 43 07", ram[3838], ram[3839]); end
    n_checks++; if (ram[3840] !== 8'h20 || ram[3999] !== 8'h07) begin n_fail++; $display("FAIL scr_fill: got %h %h, required 20 07", ram[3840], ram[3999]); end
    mcur = 1920;
  endtask

  task automatic test_reset_mid_scroll();
    int off;
    push_scroll(8'h5A);
    din   = 8'h0A;
    attr  = 8'h5A;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (1000) tick();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy: ready got %b, required 0", ready); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b, required 0", mem_we); end
    n_checks++; if (mem_a !== BASE || ready !== 1'b0) begin n_fail++; $display("FAIL mid_outs: addr=%h ready=%b, required 8000 0", mem_a, ready); end
    n_checks++; if (cursor !== 12'd0) begin n_fail++; $display("FAIL mid_cursor: got %0d, required 0", cursor); end
    exp_q.delete();
    repeat (2) tick();
    push_clear(8'h07);
    reset_n = 1'b1;
    tick();
    wait_ready(5000, off);
    n_checks++; if (off !== 4001) begin n_fail++; $display("FAIL mid_clear: ready at cycle %0d, required 4001", off); end
    n_checks++; if (cursor !== 12'd0) begin n_fail++; $display("FAIL mid_cursor_end: got %0d, required 0", cursor); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_count: %0d writes missing, required 0", exp_q.size()); end
    n_checks++; if (ram[1] !== 8'h07 || ram[3998] !== 8'h20) begin n_fail++; $display("FAIL mid_ram: got %h %h, required 07 20", ram[1], ram[3998]); end
    mcur = 0;
  endtask

  initial begin
    test_reset();
    test_printable();
    test_back_to_back();
    test_control();
    test_form_feed();
    test_scroll();
    test_reset_mid_scroll();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
